// File: rtl/shift_cmd_queue.sv
// Command FIFO and registered result stage around an external combinational barrel shifter.
// Optional feature macro: SHIFT_CMD_CNT_EN adds the done_count handshake counter.
module shift_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_data,
  input  logic [3:0]                 in_shift,
  input  logic                       in_dir,
  output logic [15:0]                sh_data,
  output logic [3:0]                 sh_shift,
  output logic                       sh_dir,
  input  logic [15:0]                sh_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_result,
  output logic [$clog2(DEPTH):0]     occupancy
`ifdef SHIFT_CMD_CNT_EN
  ,
  output logic [15:0]                done_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 21;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [EW-1:0] head;
  logic          push;
  logic          load;
  logic          empty;
  logic          vld_p0;
  logic [15:0]   res_p0;

  assign empty    = (occ == '0);
  assign in_ready = (occ != CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign load     = !empty & (!vld_p0 | out_ready);
  assign head     = mem[rd_ptr];

  // Head presentation: zeros when empty so the shifter sees a quiet operand.
  always_comb begin
    sh_data  = 16'h0000;
    sh_shift = 4'h0;
    sh_dir   = 1'b0;
    if (!empty) begin
      sh_data  = head[15:0];
      sh_shift = head[19:16];
      sh_dir   = head[20];
    end
  end

  // FIFO storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_dir, in_shift, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Stage p0: capture the shifter result for the head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      res_p0 <= 16'h0000;
    end else if (load) begin
      vld_p0 <= 1'b1;
      res_p0 <= sh_result;
    end else if (vld_p0 & out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_valid  = vld_p0;
  assign out_result = res_p0;
  assign occupancy  = occ;

`ifdef SHIFT_CMD_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= 16'h0000;
    else if (vld_p0 & out_ready) cnt <= cnt + 16'h0001;
  end

  assign done_count = cnt;
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue with a behavioural barrel shifter on the sh_* path.
module tb_shift_cmd_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shift;
  logic        in_dir;
  logic [15:0] sh_data;
  logic [3:0]  sh_shift;
  logic        sh_dir;
  logic [15:0] sh_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [$clog2(DEPTH):0] occupancy;
`ifdef SHIFT_CMD_CNT_EN
  logic [15:0] done_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  bit   burst_on = 0;
  int   burst_pops = 0;
  int   last_cyc = 0;
  bit   stop = 0;

  shift_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_dir(in_dir),
    .sh_data(sh_data), .sh_shift(sh_shift), .sh_dir(sh_dir),
    .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .occupancy(occupancy)
`ifdef SHIFT_CMD_CNT_EN
    , .done_count(done_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] shm(input logic [15:0] d, input logic [3:0] s, input logic dr);
    return dr ? (d >> s) : (d << s);
  endfunction

  assign sh_result = shm(sh_data, sh_shift, sh_dir);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output-side scoreboard: a result is consumed on the edge following this sample.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else chk("result", {16'h0, out_result}, {16'h0, exp_q.pop_front()});
      if (burst_on) begin
        if (burst_pops > 0) chk("burst_gap", cyc - last_cyc, 1);
        burst_pops++;
        last_cyc = cyc;
      end
    end
  end

  // Called from posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [3:0] s, input logic dr, input logic [15:0] e);
    bit acc = 0;
    int n = 0;
    in_data = d; in_shift = s; in_dir = dr; in_valid = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(e);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_m(input logic [15:0] d, input logic [3:0] s, input logic dr);
    send(d, s, dr, shm(d, s, dr));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_dir = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_sh", {sh_dir, sh_shift, sh_data}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single commands and latency
    out_ready = 1'b1;
    send(16'hAAAA, 4'd4, 1'b0, 16'hAAA0);
    chk("lat_n_valid", out_valid, 0);
    chk("lat_n_occ", occupancy, 1);
    chk("lat_n_head", {sh_dir, sh_shift, sh_data}, {1'b0, 4'd4, 16'hAAAA});
    @(posedge clk); #1;
    chk("lat_n1_valid", out_valid, 1);
    chk("lat_n1_result", out_result, 16'hAAA0);
    drain();
    send(16'h3333, 4'd8, 1'b1, 16'h0033);
    drain();
    chk("sh_empty", {sh_dir, sh_shift, sh_data}, 0);

    // Burst: one result per cycle
    burst_on = 1; burst_pops = 0;
    send(16'hF0F0, 4'd1,  1'b0, 16'hE1E0);
    send(16'h0F0F, 4'd15, 1'b1, 16'h0000);
    send(16'hAAAA, 4'd0,  1'b0, 16'hAAAA);
    send(16'h5555, 4'd0,  1'b1, 16'h5555);
    send(16'h0001, 4'd15, 1'b0, 16'h8000);
    send(16'h8000, 4'd15, 1'b1, 16'h0001);
    drain();
    burst_on = 0;
    chk("burst_count", burst_pops, 6);

    // Backpressure: capacity DEPTH+1
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_m(16'h1234 + 16'(i * 16'h1111), 4'(i + 1), i[0]);
    chk("bp_occ_full", occupancy, 4);
    in_data = 16'hBEEF; in_shift = 4'd3; in_dir = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_occ_hold", occupancy, 4);
      chk("bp_out_hold", out_result, shm(16'h1234, 4'd1, 1'b0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_pre_pop", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_post_pop", in_ready, 1);
    if (in_ready) exp_q.push_back(shm(16'hBEEF, 4'd3, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Wrap-around laps with random backpressure
    out_ready = 1'b0; stop = 0;
    fork
      begin
        for (int i = 0; i < 14; i++)
          send_m(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        stop = 1;
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("wrap_full_occ", occupancy, 4);
        while (!stop) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("wrap_occ_end", occupancy, 0);

    // Reset mid-stream with 3 queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_m(16'hC0DE ^ 16'(i), 4'(i), 1'b0);
    chk("mid_occ_pre", occupancy, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_post_occ", occupancy, 0);

`ifdef SHIFT_CMD_CNT_EN
    chk("cnt_rst", done_count, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_m(16'(i * 7), 4'(i), i[0]);
    drain();
    chk("cnt_10", done_count, 10);
    for (int i = 10; i < 65535; i++) send_m(16'(i), 4'(i), i[1]);
    drain();
    chk("cnt_ffff", done_count, 16'hFFFF);
    send_m(16'h0F00, 4'd4, 1'b1);
    drain();
    chk("cnt_wrap", done_count, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_cmd_queue.md
# shift_cmd_queue

Command buffer and result-capture stage wrapped around the 16-bit combinational `Barrel_Shifter`. It accepts shift commands ({data, shift amount, direction}) over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents the head command to the shifter and registers the shifter's result into an output stage with its own valid/ready handshake, decoupling producers and consumers from the shifter's combinational path.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  command present.
- `in_ready`  output  1  command accepted when `in_valid & in_ready`.
- `in_data`  input  16  operand.
- `in_shift`  input  4  shift amount 0–15.
- `in_dir`  input  1  0 = logical left, 1 = logical right.
- `sh_data`  output  16  to shifter `data`.
- `sh_shift`  output  4  to shifter `shift`.
- `sh_dir`  output  1  to shifter `dir`.
- `sh_result`  input  16  from shifter `result`.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  result consumed when `out_valid & out_ready`.
- `out_result`  output  16  registered shift result.
- `occupancy`  output  $clog2(DEPTH)+1  FIFO entries currently held.

## Operation
- FIFO storage: DEPTH × 21 bits {dir, shift[3:0], data[15:0]}. Write/read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter.
- Push: `in_valid & in_ready`; `in_ready = (occupancy != DEPTH)`. There is no pass-through when full, even if a pop occurs in the same cycle.
- `sh_*` carry the head entry when `occupancy != 0`, otherwise all zeros.
- Output stage: `load = (occupancy != 0) & (!out_valid | out_ready)`. On load:
  - `out_result <= sh_result`
  - `out_valid <= 1`
  - read pointer advances (pop).
- `out_valid` clears when `out_ready & out_valid & !load`.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Push into an empty FIFO: the entry becomes head the next cycle, not the same cycle.
- Commands are delivered strictly in order; none are dropped or duplicated.
- Shift amount 0 passes data unchanged. Shift semantics are owned by `Barrel_Shifter`; this block never modifies operands.

## Timing
- Reset (async assert, synchronous-to-clk release):
  - `occupancy = 0`, pointers 0
  - `in_ready = 1`
  - `out_valid = 0`, `out_result = 16'h0000`
  - `sh_data/sh_shift/sh_dir = 0`
  - FIFO contents don't-care.
- Latency: command accepted at edge N → `out_valid = 1` with its result after edge N+1, provided the output stage is free.
- Throughput: one command per cycle sustained while `out_ready = 1`.
- Backpressure: with `out_ready = 0`, `out_valid` and `out_result` hold. The FIFO fills; `in_ready` drops the cycle after occupancy reaches DEPTH. Capacity is DEPTH + 1 commands (FIFO plus output register).
- The combinational path is `sh_*` → shifter → `sh_result` → `out_result`, all within one cycle.
- Reset mid-operation: all queued and output-held commands are discarded; outputs return to reset values immediately.

## Configuration
- `SHIFT_CMD_CNT_EN` defined:
  - adds output port `done_count [15:0]`, reset 0.
  - increments on every `out_valid & out_ready` handshake, wrapping 16'hFFFF → 16'h0000.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: assert `rst_n = 0` mid-stream with 3 queued → next cycle `occupancy = 0`, `out_valid = 0`, `out_result = 0`, `in_ready = 1`.
- Single command, `out_ready = 1`: push {`16'hAAAA`, 4, 0} at edge N → after N+1, `out_valid = 1`, `out_result = 16'hAAA0`; push {`16'h3333`, 8, 1} → `16'h0033`.
- Burst of 6 commands, `out_ready` tied 1:
  - {`16'hF0F0`,1,0}, {`16'h0F0F`,15,1}, {`16'hAAAA`,0,0}, {`16'h5555`,0,1}, {`16'h0001`,15,0}, {`16'h8000`,15,1}
  - results in order: `16'hE1E0`, `16'h0000`, `16'hAAAA`, `16'h5555`, `16'h8000`, `16'h0001`
  - one result per cycle.
- Backpressure with DEPTH = 4, `out_ready = 0`:
  - 5 pushes accepted, 6th stalls with `in_ready = 0` and `occupancy = 4`.
  - Release `out_ready` → all 5 results drain in order; the 6th is accepted the cycle after the first pop.
- Simultaneous push/pop at full: `occupancy` stays 4, `in_ready` stays 0 until the pop completes, and pointer wrap-around delivers results in order across ≥2 full laps.
- With `SHIFT_CMD_CNT_EN`:
  - 10 handshakes → `done_count = 10`.
  - Preload to `16'hFFFF` via 65535 handshakes (or force), one more → `16'h0000`.
